// File: rtl/rdac3v_8bit_seq_ctrl.sv
// Sequencer sharing one 8-bit resistor DAC between two requesters: power-up wake,
// round-robin code arbitration, post-update settling and completion reporting.
module rdac3v_8bit_seq_ctrl #(
    parameter int WAKE_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       dac_ena,
    output logic [7:0] dac_b,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LOAD   = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic [7:0]       dac_b_q, dac_b_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;

    logic             idle_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             xfer_s;

    // Arbitration: only in service while enabled; rr_q names the preferred requester on contention.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        idle_s   = (state_q == ST_IDLE) && enable;
        if (idle_s) begin
            if (req0_valid && req1_valid) begin
                grant0_s = ~rr_q;
                grant1_s = rr_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
        xfer_s = grant0_s | grant1_s;
    end

    // Next-state logic; dropping enable overrides everything and suppresses done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        dac_b_d   = dac_b_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (xfer_s) begin
                    dac_b_d   = grant1_s ? req1_data : req0_data;
                    done_id_d = grant1_s;
                    rr_d      = ~grant1_s;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= {CNT_W{1'b0}};
            rr_q      <= 1'b0;
            dac_b_q   <= 8'h00;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            dac_b_q   <= dac_b_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign dac_ena    = (state_q != ST_OFF);
    assign busy       = (state_q == ST_WAKE) || (state_q == ST_SETTLE);
    assign dac_b      = dac_b_q;
    assign done       = done_q;
    assign done_id    = done_id_q;

endmodule

// File: tb/tb_rdac3v_8bit_seq_ctrl.sv
// Scoreboard bench: default-parameter DUT plus a WAKE=1/SETTLE=1 instance for boundary timing.
module tb_rdac3v_8bit_seq_ctrl;

    logic       clk;
    logic       rst, enable;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data, dac_b;
    logic       dac_ena, busy, done, done_id;

    logic       b_rst, b_enable;
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [7:0] b_req0_data, b_req1_data, b_dac_b;
    logic       b_dac_ena, b_busy, b_done, b_done_id;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [8:0] sb_q[$];
    logic [8:0] b_q[$];
    logic [8:0] mon_e, b_mon_e;

    rdac3v_8bit_seq_ctrl u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .dac_ena(dac_ena), .dac_b(dac_b), .busy(busy), .done(done), .done_id(done_id)
    );

    rdac3v_8bit_seq_ctrl #(.WAKE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(16)) u_bnd (
        .clk(clk), .rst(b_rst), .enable(b_enable),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .dac_ena(b_dac_ena), .dac_b(b_dac_b), .busy(b_busy), .done(b_done), .done_id(b_done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main scoreboard monitor: done pops the next expected {id, code}.
    always @(negedge clk) begin
        if (req0_valid && req1_valid)
            chk("one_ready", 32'(req0_ready && req1_ready), 32'd0);
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_id", 32'(done_id), 32'(mon_e[8]));
                chk("done_dac_b", 32'(dac_b), 32'(mon_e[7:0]));
            end
        end
    end

    // Boundary-instance monitor.
    always @(negedge clk) begin
        if (b_done) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_done", 32'(b_done), 32'd0);
            end else begin
                b_mon_e = b_q.pop_front();
                chk("b_done_id", 32'(b_done_id), 32'(b_mon_e[8]));
                chk("b_done_dac_b", 32'(b_dac_b), 32'(b_mon_e[7:0]));
            end
        end
    end

    task automatic wait_xfer(output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && n < 60);
        chk("xfer_timeout", 32'(n < 60), 32'd1);
        c = cyc;
    endtask

    task automatic count_busy(output int n, input logic [7:0] hold_b);
        n = 0;
        while (busy && n < 100) begin
            chk("busy_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("busy_dac_b", 32'(dac_b), 32'(hold_b));
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         c[4];
        logic [7:0] bd[4];
        bd[0] = 8'h01; bd[1] = 8'h80; bd[2] = 8'hFF; bd[3] = 8'h5A;

        rst = 1'b1; enable = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        b_rst = 1'b1; b_enable = 1'b0;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = 8'h00; b_req1_data = 8'h00;

        // Reset and wake, with a pending A5 from requester 0.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_dac_ena", 32'(dac_ena), 32'd0);
        chk("rst_dac_b", 32'(dac_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        @(posedge clk);
        #1 enable = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5;
        sb_q.push_back({1'b0, 8'hA5});
        @(negedge clk);
        chk("ena_lag", 32'(dac_ena), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ena_rise", 32'(dac_ena), 32'd1);
        count_busy(n, 8'h00);
        chk("wake_len", 32'(n), 32'd16);
        chk("wake_ready", 32'(req0_ready), 32'd1);

        // Single update settle.
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("upd_dac_b", 32'(dac_b), 32'hA5);
        count_busy(n, 8'hA5);
        chk("settle_len", 32'(n), 32'd8);
        chk("settle_done", 32'(done), 32'd1);

        // Contention: pointer now favours requester 1.
        @(posedge clk);
        #1 req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h10; req1_data = 8'h20;
        sb_q.push_back({1'b1, 8'h20}); sb_q.push_back({1'b0, 8'h10});
        sb_q.push_back({1'b1, 8'h20}); sb_q.push_back({1'b0, 8'h10});
        for (int i = 0; i < 4; i++) begin
            wait_xfer(c[i]);
            if (i > 0) chk("rr_spacing", 32'(c[i] - c[i-1]), 32'd9);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Abort on 3rd settle cycle of 7F.
        @(posedge clk);
        #1 req0_valid = 1'b1; req0_data = 8'h7F;
        wait_xfer(c[0]);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dac_ena", 32'(dac_ena), 32'd0);
        chk("abort_dac_b", 32'(dac_b), 32'h7F);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_hold_b", 32'(dac_b), 32'h7F);
            @(negedge clk);
        end

        // Re-enable: full wake before requester 0 is served.
        @(posedge clk);
        #1 enable = 1'b1; req0_valid = 1'b1; req0_data = 8'h33;
        @(posedge clk);
        @(negedge clk);
        count_busy(n, 8'h7F);
        chk("rewake_len", 32'(n), 32'd16);
        chk("rewake_ready", 32'(req0_ready), 32'd1);

        // Reset during the settle of 33 (pointer now favours requester 1).
        @(posedge clk);
        #1 req0_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_dac_b", 32'(dac_b), 32'd0);
        chk("mrst_dac_ena", 32'(dac_ena), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h10; req1_data = 8'h20;
        sb_q.push_back({1'b0, 8'h10}); sb_q.push_back({1'b1, 8'h20});
        wait_xfer(c[0]);
        wait_xfer(c[1]);
        chk("mrst_spacing", 32'(c[1] - c[0]), 32'd9);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Boundary instance: WAKE=1, SETTLE=1, back-to-back requester 1 codes.
        @(posedge clk);
        #1 b_rst = 1'b0;
        @(posedge clk);
        #1 b_enable = 1'b1; b_req1_valid = 1'b1; b_req1_data = bd[0];
        @(posedge clk);
        @(negedge clk);
        chk("b_wake_busy", 32'(b_busy), 32'd1);
        chk("b_wake_ready", 32'(b_req1_ready), 32'd0);
        @(negedge clk);
        chk("b_wake_end", 32'(b_busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("b_ready", 32'(b_req1_ready), 32'd1);
            b_q.push_back({1'b1, bd[k]});
            @(posedge clk);
            #1;
            if (k < 3) b_req1_data = bd[k+1];
            else       b_req1_valid = 1'b0;
            @(negedge clk);
            chk("b_settle_busy", 32'(b_busy), 32'd1);
            chk("b_dac_b", 32'(b_dac_b), 32'(bd[k]));
            chk("b_settle_ready", 32'(b_req1_ready), 32'd0);
            @(negedge clk);
            chk("b_busy_fall", 32'(b_busy), 32'd0);
            chk("b_done", 32'(b_done), 32'd1);
        end
        @(negedge clk);
        chk("b_drain", 32'(b_q.size()), 32'd0);
        chk("b_idle_done", 32'(b_done), 32'd0);
        chk("final_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
